// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use / data-miss / redirect hazard control with saturating perf counters
module hazard_ctrl_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_MEM,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic [REG_W-1:0] destEX,
  input  logic             regWEN_EX,
  input  logic             memread_EX,
  input  logic [1:0]       PCSrc,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             stall_IDEX,
  output logic             stall_EXMEM,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN, LOADUSE, DWAIT} state_t;
  state_t           fsm_q, fsm_d;
  logic [1:0]       bub_cnt_q, bub_cnt_d;
  logic             redirect_pend_q, redirect_pend_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  logic             hazard_lu, redirect, dwait, lu_stall;
  assign hazard_lu = memread_EX & regWEN_EX & (destEX != '0) &
                     ((rs_used & (rs == destEX)) | (rt_used & (rt == destEX)));
  assign redirect  = PCSrc != 2'b00;
  // the dhit cycle of a miss is a normal RUN cycle, so DWAIT only holds while dhit is low
  assign dwait     = (dmem_req_MEM | (fsm_q == DWAIT)) & ~dhit;
  assign lu_stall  = ~redirect & ((fsm_q == LOADUSE) | hazard_lu);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q           <= RUN;
      bub_cnt_q       <= 2'd0;
      redirect_pend_q <= 1'b0;
      stall_cycles_q  <= '0;
      flush_events_q  <= '0;
    end else begin
      fsm_q           <= fsm_d;
      bub_cnt_q       <= bub_cnt_d;
      redirect_pend_q <= redirect_pend_d;
      stall_cycles_q  <= stall_cycles_d;
      flush_events_q  <= flush_events_d;
    end
  end
  // a data miss abandons any remaining load-use bubbles; hazards are re-evaluated on dhit
  always_comb begin
    fsm_d           = RUN;
    bub_cnt_d       = 2'd0;
    redirect_pend_d = redirect_pend_q & ~ihit;
    if (dwait) begin
      fsm_d           = DWAIT;
      redirect_pend_d = redirect_pend_q;
    end else if (redirect) begin
      redirect_pend_d = ~ihit;
    end else if (fsm_q == LOADUSE) begin
      fsm_d     = (bub_cnt_q == 2'd0) ? RUN : LOADUSE;
      bub_cnt_d = (bub_cnt_q == 2'd0) ? 2'd0 : bub_cnt_q - 2'd1;
    end else if (hazard_lu && LOAD_LAT > 1) begin
      fsm_d     = LOADUSE;
      bub_cnt_d = 2'(LOAD_LAT - 2);
    end
  end
  always_comb begin
    stall_PC    = ~RST & (dwait | (~redirect & (lu_stall | ~ihit)));
    stall_IFID  = stall_PC;
    stall_IDEX  = ~RST & dwait;
    stall_EXMEM = ~RST & dwait;
    flush_IFID  = ~RST & ~dwait & (redirect | (redirect_pend_q & ihit));
    flush_IDEX  = ~RST & ~dwait & (redirect | lu_stall);
  end
  always_comb begin
    stall_cycles_d = (stall_PC & ~&stall_cycles_q) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    flush_events_d = (flush_IFID & ~&flush_events_q) ? flush_events_q + CNT_W'(1) : flush_events_q;
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: four parameter variants driven in lockstep, checked against a cycle model
module tb_hazard_ctrl_unit;
  localparam int N = 4;
  localparam int LATS [N] = '{1, 3, 4, 2};
  logic CLK = 0, RST = 1, ihit = 1, dhit = 1, dmem_req_MEM = 0;
  logic rs_used = 0, rt_used = 0, regWEN_EX = 0, memread_EX = 0;
  logic [4:0] rs = 0, rt = 0, destEX = 0;
  logic [1:0] PCSrc = 0;
  logic [5:0] o [N];
  logic [15:0] sc [N], fe [N];
  int checks = 0, errors = 0;
  bit m_dw [N], m_pend [N];
  int m_left [N], m_sc [N], m_fe [N];
  always #5 CLK = ~CLK;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g == 3) ? 2 : 16;
    logic [CW-1:0] sc_w, fe_w;
    logic s_pc, s_if, s_ix, s_em, f_if, f_ix;
    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(LATS[g]), .CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req_MEM(dmem_req_MEM),
      .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used), .destEX(destEX),
      .regWEN_EX(regWEN_EX), .memread_EX(memread_EX), .PCSrc(PCSrc),
      .stall_PC(s_pc), .stall_IFID(s_if), .stall_IDEX(s_ix), .stall_EXMEM(s_em),
      .flush_IFID(f_if), .flush_IDEX(f_ix), .stall_cycles(sc_w), .flush_events(fe_w));
    assign o[g]  = {s_pc, s_if, s_ix, s_em, f_if, f_ix};
    assign sc[g] = 16'(sc_w);
    assign fe[g] = 16'(fe_w);
  end
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_dw[k] = 0; m_pend[k] = 0; m_left[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
    end
  endtask
  task automatic step(string tag);
    bit n_dw [N], n_pend [N];
    int n_left [N], n_sc [N], n_fe [N];
    bit red, haz, dw, lu, spc, fi, fx;
    logic [5:0] exp_o;
    int cmax;
    @(negedge CLK);
    red = PCSrc != 2'b00;
    haz = memread_EX && regWEN_EX && destEX != 0 &&
          ((rs_used && rs == destEX) || (rt_used && rt == destEX));
    for (int k = 0; k < N; k++) begin
      dw = (dmem_req_MEM || m_dw[k]) && !dhit;
      lu = !red && (m_left[k] > 0 || haz);
      spc = dw || (!red && (lu || !ihit));
      fi = !dw && (red || (m_pend[k] && ihit));
      fx = !dw && (red || lu);
      exp_o = {spc, spc, dw, dw, fi, fx};
      checks++;
      assert (o[k] === exp_o) else begin
        errors++; $error("FAIL %s[%0d] outs got %b exp %b", tag, k, o[k], exp_o);
      end
      checks++;
      assert (sc[k] === 16'(m_sc[k])) else begin
        errors++; $error("FAIL %s[%0d] stall_cycles got %0d exp %0d", tag, k, sc[k], m_sc[k]);
      end
      checks++;
      assert (fe[k] === 16'(m_fe[k])) else begin
        errors++; $error("FAIL %s[%0d] flush_events got %0d exp %0d", tag, k, fe[k], m_fe[k]);
      end
      cmax = (k == 3) ? 3 : 65535;
      n_dw[k] = dw;
      n_pend[k] = dw ? m_pend[k] : red ? !ihit : (m_pend[k] && !ihit);
      n_left[k] = (dw || red) ? 0 : (m_left[k] > 0) ? m_left[k] - 1 : haz ? LATS[k] - 1 : 0;
      n_sc[k] = (spc && m_sc[k] < cmax) ? m_sc[k] + 1 : m_sc[k];
      n_fe[k] = (fi && m_fe[k] < cmax) ? m_fe[k] + 1 : m_fe[k];
    end
    @(posedge CLK);
    for (int k = 0; k < N; k++) begin
      m_dw[k] = n_dw[k]; m_pend[k] = n_pend[k]; m_left[k] = n_left[k];
      m_sc[k] = n_sc[k]; m_fe[k] = n_fe[k];
    end
    #1;
  endtask
  task automatic check_reset(string tag);
    for (int k = 0; k < N; k++) begin
      checks++;
      assert (o[k] === 6'd0 && sc[k] === 16'd0 && fe[k] === 16'd0) else begin
        errors++; $error("FAIL %s[%0d] got outs %b sc %0d fe %0d exp all zero", tag, k, o[k], sc[k], fe[k]);
      end
    end
  endtask
  task automatic idle();
    ihit = 1; dhit = 1; dmem_req_MEM = 0; PCSrc = 0; memread_EX = 0; regWEN_EX = 0;
    rs_used = 0; rt_used = 0; rs = 0; rt = 0; destEX = 0;
  endtask
  task automatic load_use(logic [4:0] r);
    memread_EX = 1; regWEN_EX = 1; destEX = r; rs = r; rs_used = 1;
  endtask
  initial begin
    model_reset();
    RST = 1; ihit = 0; dmem_req_MEM = 1; dhit = 0; PCSrc = 2'b01;
    repeat (2) @(posedge CLK);
    #1;
    check_reset("reset");
    RST = 0; idle();
    step("idle");
    load_use(5'd5); step("lu_hit");
    idle(); repeat (4) step("lu_after");
    load_use(5'd0); step("lu_r0");
    idle(); step("lu_r0_after");
    dmem_req_MEM = 1; dhit = 0; repeat (4) step("dmiss");
    dhit = 1; step("dhit");
    idle(); step("dmiss_after");
    PCSrc = 2'b01; ihit = 0; step("redir");
    PCSrc = 2'b00; repeat (2) step("redir_wait");
    ihit = 1; step("redir_late_ihit");
    step("redir_after");
    load_use(5'd7); step("lu4_first");
    idle(); PCSrc = 2'b10; step("lu4_redir");
    PCSrc = 2'b00; repeat (3) step("lu4_after");
    ihit = 0; repeat (5) step("sat");
    ihit = 1; step("sat_after");
    dmem_req_MEM = 1; dhit = 0; repeat (2) step("dmiss_rst");
    RST = 1; #1;
    check_reset("rst_mid_dwait");
    @(posedge CLK); #1;
    check_reset("rst_held");
    model_reset();
    RST = 0; idle();
    step("post_rst");
    for (int i = 0; i < 500; i++) begin
      ihit = ($urandom_range(3) != 0);
      dmem_req_MEM = ($urandom_range(4) == 0);
      dhit = ($urandom_range(2) != 0);
      PCSrc = ($urandom_range(7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      memread_EX = $urandom_range(1); regWEN_EX = ($urandom_range(3) != 0);
      destEX = 5'($urandom_range(3)); rs = 5'($urandom_range(3)); rt = 5'($urandom_range(3));
      rs_used = $urandom_range(1); rt_used = $urandom_range(1);
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the five-stage datapath, replacing the purely combinational stall/flush decoder. It detects load-use hazards with a configurable load-to-use latency, freezes the whole pipe on outstanding data-memory accesses, and squashes wrong-path fetches after an EX-stage redirect, including one that lands while a fetch is still in flight. It sits beside the datapath, takes register indices and stage status, drives per-latch stall/flush enables, and keeps saturating performance counters.

## Interface
Parameters:
- REG_W, 5, register index width
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..4)
- CNT_W, 16, performance counter width

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- dmem_req_MEM  in  1  load/store occupies MEM
- rs, rt  in  REG_W  source registers of the ID instruction
- rs_used, rt_used  in  1  ID instruction reads rs / rt
- destEX  in  REG_W  destination of the EX instruction
- regWEN_EX, memread_EX  in  1  EX instruction writes a register / is a load
- PCSrc  in  2  00 = sequential, any other value = redirect resolved in EX
- stall_PC, stall_IFID, stall_IDEX, stall_EXMEM  out  1  hold that register
- flush_IFID, flush_IDEX  out  1  load a bubble into that latch
- stall_cycles, flush_events  out  CNT_W  saturating counters

## Operation
- Registered state: fsm (RUN, LOADUSE, DWAIT), bub_cnt (2 bits), redirect_pend, both counters.
- hazard_lu = memread_EX & regWEN_EX & (destEX != 0) & ((rs_used & rs == destEX) | (rt_used & rt == destEX)).
- redirect = (PCSrc != 2'b00).
- Priority per cycle: DWAIT condition > redirect > load-use > fetch wait.
- DWAIT:
  - Enter DWAIT when dmem_req_MEM & !dhit.
  - In DWAIT, assert all four stall outputs. Assert no flush.
  - Leave DWAIT to RUN in the cycle dhit = 1. That cycle is a normal cycle and its other conditions are evaluated.
  - A redirect seen in DWAIT is acted on only when dhit arrives.
- Redirect:
  - Assert flush_IFID and flush_IDEX for one cycle. Never stall PC.
  - If ihit = 0 in that cycle, set redirect_pend.
  - While redirect_pend = 1, each ihit also asserts flush_IFID, then clears redirect_pend.
  - A redirect overrides load-use and cancels LOADUSE: state goes to RUN and bub_cnt to 0.
- Load-use in RUN:
  - Assert stall_PC, stall_IFID and flush_IDEX.
  - If LOAD_LAT > 1, go to LOADUSE with bub_cnt = LOAD_LAT-2.
- LOADUSE:
  - Keep asserting stall_PC, stall_IFID and flush_IDEX.
  - Decrement bub_cnt each cycle. Return to RUN in the cycle bub_cnt = 0.
- Fetch wait: ihit = 0 in RUN with no other event asserts stall_PC and stall_IFID only.
- Counters:
  - stall_cycles increments in any cycle where stall_PC = 1.
  - flush_events increments in any cycle where flush_IFID = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- While RST = 1, all outputs are 0, fsm = RUN, bub_cnt = 0, redirect_pend = 0 and both counters are 0.
- Reset mid-stall clears state immediately (asynchronous). The first cycle after release is RUN.
- Stall and flush outputs are combinational from the current inputs and the registered state, settling within the same cycle.
- State and counters update on the CLK rising edge.
- Load-use costs exactly LOAD_LAT cycles of stall_PC, counted from the cycle the hazard is first seen.
- Redirect costs 1 flush cycle, plus 1 extra flush_IFID on the late ihit when redirect_pend was set.
- Simultaneous redirect and pending squash: treat as a fresh redirect, with redirect_pend = !ihit.
- Register 0 never causes a load-use hazard.

## Test plan
- LOAD_LAT=1: lw to r5 in EX, ID add reads rs=r5 -> 1 cycle of stall_PC=stall_IFID=flush_IDEX=1, then all 0; stall_cycles=1.
- LOAD_LAT=3: same stimulus -> 3 consecutive stall/bubble cycles, then RUN; stall_cycles=3. Repeat with destEX=0 -> no stall.
- Data miss: dmem_req_MEM=1, dhit=0 for 4 cycles -> all four stalls high for 4 cycles, no flush; dhit=1 on cycle 5 -> stalls drop that cycle.
- Redirect with ihit=0: PCSrc=01 -> flush_IFID and flush_IDEX for 1 cycle. With ihit low for 2 more cycles, then high -> flush_IFID=1 on that ihit cycle only; flush_events=2.
- Redirect during LOADUSE (LOAD_LAT=4, PCSrc=10 on 2nd bubble) -> flush both latches, stall_PC=0, fsm back to RUN next cycle.
- CNT_W=2: 5 stall cycles -> stall_cycles holds 3. Assert RST mid-DWAIT -> all outputs 0 immediately, and RUN on release.
